// File: rtl/if_fetch_bpu_if.sv
// Fetch-stage bus: EX feedback, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = the surrounding pipeline / memory.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface if_fetch_bpu_if;
    logic                     PC_w;
    logic                     EX_Redirect;
    logic [`PC_WIDTH-1:0]     EX_Redirect_PC;
    logic                     EX_Br_Valid;
    logic [`PC_WIDTH-1:0]     EX_Br_PC;
    logic                     EX_Br_Taken;
    logic [`PC_WIDTH-1:0]     EX_Br_Target;
    logic [`PC_WIDTH-1:0]     IM_Addr;
    logic [`INSTR_WIDTH-1:0]  IM_Data;
    logic [`PC_WIDTH-1:0]     IF_PC;
    logic [`INSTR_WIDTH-1:0]  IF_Instr;
    logic                     IF_Predict_Taken;

    modport master (
        input  PC_w, EX_Redirect, EX_Redirect_PC,
        input  EX_Br_Valid, EX_Br_PC, EX_Br_Taken, EX_Br_Target,
        input  IM_Data,
        output IM_Addr, IF_PC, IF_Instr, IF_Predict_Taken
    );

    modport slave (
        output PC_w, EX_Redirect, EX_Redirect_PC,
        output EX_Br_Valid, EX_Br_PC, EX_Br_Taken, EX_Br_Target,
        output IM_Data,
        input  IM_Addr, IF_PC, IF_Instr, IF_Predict_Taken
    );
endinterface

// File: rtl/if_fetch_bpu.sv
// Instruction-fetch stage with 2-bit BHT + direct-mapped BTB prediction.
// Prediction is built only when BPU_PREDICT_EN is defined; otherwise fetch is static not-taken.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module if_fetch_bpu #(
    parameter logic [`PC_WIDTH-1:0] RESET_PC  = {`PC_WIDTH{1'b0}},
    parameter int                   BHT_IDX_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_bpu_if.master bus
);
    localparam int PCW = `PC_WIDTH;
    localparam logic [PCW-1:0] PC_STEP = {{(PCW-3){1'b0}}, 3'b100};

    logic [PCW-1:0] pc_r;
    logic [PCW-1:0] next_pc_s;
    logic           predict_s;
    logic [PCW-1:0] pred_target_s;

`ifdef BPU_PREDICT_EN
    localparam int TAG_W   = PCW - BHT_IDX_W - 2;
    localparam int ENTRIES = 1 << BHT_IDX_W;

    logic [1:0]           bht_r        [ENTRIES];
    logic [ENTRIES-1:0]   btb_valid_r;
    logic [TAG_W-1:0]     btb_tag_r    [ENTRIES];
    logic [PCW-1:0]       btb_target_r [ENTRIES];

    logic [BHT_IDX_W-1:0] f_idx_s;
    logic [TAG_W-1:0]     f_tag_s;
    logic [BHT_IDX_W-1:0] u_idx_s;
    logic [TAG_W-1:0]     u_tag_s;
    logic                 unused_s;

    assign f_idx_s  = pc_r[BHT_IDX_W+1:2];
    assign f_tag_s  = pc_r[PCW-1:BHT_IDX_W+2];
    assign u_idx_s  = bus.EX_Br_PC[BHT_IDX_W+1:2];
    assign u_tag_s  = bus.EX_Br_PC[PCW-1:BHT_IDX_W+2];
    assign unused_s = ^bus.EX_Br_PC[1:0];

    // Combinational lookup of the current PC; sees storage before this edge's update.
    always_comb begin
        predict_s     = 1'b0;
        pred_target_s = btb_target_r[f_idx_s];
        if (btb_valid_r[f_idx_s] && (btb_tag_r[f_idx_s] == f_tag_s)) begin
            predict_s = bht_r[f_idx_s][1];
        end else begin
            predict_s = 1'b0;
        end
    end

    // Predictor training from resolved EX branches; counter trains even on tag mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                bht_r[i]        <= 2'b01;
                btb_tag_r[i]    <= {TAG_W{1'b0}};
                btb_target_r[i] <= {PCW{1'b0}};
            end
        end else if (bus.EX_Br_Valid) begin
            if (bus.EX_Br_Taken) begin
                if (bht_r[u_idx_s] != 2'b11) begin
                    bht_r[u_idx_s] <= bht_r[u_idx_s] + 2'b01;
                end
                btb_valid_r[u_idx_s]  <= 1'b1;
                btb_tag_r[u_idx_s]    <= u_tag_s;
                btb_target_r[u_idx_s] <= bus.EX_Br_Target;
            end else begin
                if (bht_r[u_idx_s] != 2'b00) begin
                    bht_r[u_idx_s] <= bht_r[u_idx_s] - 2'b01;
                end
            end
        end
    end
`else
    logic unused_s;

    assign predict_s     = 1'b0;
    assign pred_target_s = {PCW{1'b0}};
    assign unused_s      = ^{bus.EX_Br_Valid, bus.EX_Br_PC, bus.EX_Br_Taken, bus.EX_Br_Target};
`endif

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc_s = pc_r;
        if (bus.EX_Redirect) begin
            next_pc_s = bus.EX_Redirect_PC;
        end else if (!bus.PC_w) begin
            next_pc_s = pc_r;
        end else if (predict_s) begin
            next_pc_s = pred_target_s;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign bus.IM_Addr          = pc_r;
    assign bus.IF_PC            = pc_r;
    assign bus.IF_Instr         = bus.IM_Data;
    assign bus.IF_Predict_Taken = predict_s;
endmodule
